// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared defaults and state encoding for the ECG processing chain
//
// Purpose : common parameters for the QRS-detection chain blocks, plus the
//           FILL/RUN state encoding used by the moving-window integrator.
// Contents: ECG_WIDTH   - default signed sample width of the differentiator output
//           MWI_N_LOG2  - default log2 of the integration window length
//           mwi_state_t - integrator fill state
//           mwi_acc_width() - accumulator width for a given sample width / window

package ecg_pkg;

  localparam int ECG_WIDTH  = 16;
  localparam int MWI_N_LOG2 = 5;

  typedef enum logic {
    MWI_FILL = 1'b0,
    MWI_RUN  = 1'b1
  } mwi_state_t;

  // A window of 2^n_log2 squares of width-bit samples needs 2*width + n_log2
  // bits to hold the running sum without wrapping.
  function automatic int mwi_acc_width(input int width, input int n_log2);
    return 2 * width + n_log2;
  endfunction

endpackage

// File: rtl/mwi_delay_line.sv
// rtl/mwi_delay_line.sv - window delay line for the moving-window integrator
//
// Purpose : 2^ADDR_W x DATA_W simple dual-port memory, one write port and one
//           synchronous read port. A read and write to the same address in the
//           same cycle returns the old contents. No reset, so it maps onto
//           block or distributed RAM.
// Ports   : clk     - clock
//           wr_en   - write strobe
//           wr_addr - write address
//           wr_data - write data
//           rd_en   - read strobe; rd_data updates only when set
//           rd_addr - read address
//           rd_data - registered read data

module mwi_delay_line #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Both accesses use non-blocking assignment, so a same-address read sees
  // the value from before this edge's write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_moving_window_integrator.sv
// rtl/axis_moving_window_integrator.sv - streaming moving-window mean of squared samples
//
// Purpose : y[n] = (sum of x[k]^2 over the last N = 2^N_LOG2 samples) >> N_LOG2,
//           with samples before reset treated as zero. Two register stages:
//           stage 1 squares the sample and reads the oldest window entry,
//           stage 2 updates the running sum, writes the new square and
//           registers the output.
// Ports   : clk           - clock, rising edge
//           rst_n         - asynchronous active-low reset
//           s_axis_tvalid - input sample valid
//           s_axis_tdata  - signed WIDTH-bit input sample
//           s_axis_tready - input sample accepted this cycle when valid
//           m_axis_tvalid - output sample valid
//           m_axis_tdata  - unsigned 2*WIDTH-bit window mean of squares
//           m_axis_tready - downstream accepts the output this cycle

module axis_moving_window_integrator
  import ecg_pkg::*;
#(
  parameter int WIDTH  = ECG_WIDTH,
  parameter int N_LOG2 = MWI_N_LOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  output logic                 s_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  input  logic                 m_axis_tready
);

  localparam int SQ_W  = 2 * WIDTH;
  localparam int ACC_W = mwi_acc_width(WIDTH, N_LOG2);
  localparam int N     = 1 << N_LOG2;
  localparam int CNT_W = N_LOG2 + 1;

  logic                    en;
  logic                    r_ready;
  logic                    xfer;
  logic                    s1_valid;
  logic                    s2_fire;
  logic signed [SQ_W-1:0]  x_ext;
  logic [SQ_W-1:0]         sq_next;
  logic [SQ_W-1:0]         sq;
  logic [N_LOG2-1:0]       wr_ptr;
  logic [N_LOG2-1:0]       rd_addr;
  logic [SQ_W-1:0]         old_raw;
  logic [SQ_W-1:0]         old;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic [CNT_W-1:0]        fill_cnt;
  mwi_state_t              state;
  mwi_state_t              state_next;

  // Whole pipeline advances together; it stalls only when the output
  // register is full and downstream is not taking it.
  assign en            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en & r_ready;
  assign xfer          = s_axis_tvalid & s_axis_tready;
  assign s2_fire       = s1_valid & en;

  // Squaring at full SQ_W width keeps (-2^(WIDTH-1))^2 exact.
  assign x_ext   = {{WIDTH{s_axis_tdata[WIDTH-1]}}, s_axis_tdata};
  assign sq_next = x_ext * x_ext;

  // Held low for one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      sq       <= '0;
    end else if (en) begin
      s1_valid <= xfer;
      if (xfer) begin
        sq <= sq_next;
      end
    end
  end

  // The read is for the slot this sample will overwrite. When stage 2 is
  // writing this same edge, wr_ptr is about to advance, so look one ahead.
  assign rd_addr = s2_fire ? wr_ptr + N_LOG2'(1) : wr_ptr;

  mwi_delay_line #(
    .ADDR_W (N_LOG2),
    .DATA_W (SQ_W)
  ) u_delay_line (
    .clk     (clk),
    .wr_en   (s2_fire),
    .wr_addr (wr_ptr),
    .wr_data (sq),
    .rd_en   (xfer),
    .rd_addr (rd_addr),
    .rd_data (old_raw)
  );

  // ---------------------------------------------------------------- stage 2
  // Delay-line contents survive reset, so anything read before the window
  // has been filled once is stale and must not be subtracted.
  assign old      = (state == MWI_FILL) ? '0 : old_raw;
  assign acc_next = acc + ACC_W'(sq) - ACC_W'(old);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      wr_ptr        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (s2_fire) begin
        acc           <= acc_next;
        wr_ptr        <= wr_ptr + N_LOG2'(1);
        m_axis_tdata  <= acc_next[ACC_W-1:N_LOG2];
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ fill state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MWI_FILL;
      fill_cnt <= '0;
    end else begin
      state <= state_next;
      if (s2_fire && (state == MWI_FILL)) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MWI_FILL: begin
        if (s2_fire && (fill_cnt == CNT_W'(N - 1))) begin
          state_next = MWI_RUN;
        end
      end
      MWI_RUN:  state_next = MWI_RUN;
      default:  state_next = MWI_FILL;
    endcase
  end

endmodule

// File: tb/tb_axis_moving_window_integrator.sv
// tb/tb_axis_moving_window_integrator.sv - self-checking bench for axis_moving_window_integrator

module tb_axis_moving_window_integrator;

  logic               clk;
  logic               rst_n;
  logic               s_axis_tvalid;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tready;
  logic               m_axis_tvalid;
  logic [31:0]        m_axis_tdata;
  logic               m_axis_tready;

  int     n_cmp;
  int     n_err;
  longint exp_q[$];
  longint hist[$];
  longint out_q[$];

  axis_moving_window_integrator #(
    .WIDTH  (16),
    .N_LOG2 (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference model: direct window sum of the last 32 accepted squares.
  always @(negedge clk) begin : monitor
    longint e;
    longint sq;
    longint sum;
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_data", longint'(m_axis_tdata), e);
        end
        out_q.push_back(longint'(m_axis_tdata));
      end
      if (s_axis_tvalid && s_axis_tready) begin
        sq = longint'(s_axis_tdata) * longint'(s_axis_tdata);
        hist.push_back(sq);
        if (hist.size() > 32) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        exp_q.push_back(sum >>> 5);
      end
    end
  end

  // One clock: decide acceptance at the falling edge, return #1 after the rising edge.
  task automatic step(output bit took);
    @(negedge clk);
    took = s_axis_tvalid && s_axis_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    exp_q.delete();
    hist.delete();
    out_q.delete();
    #1;
    check_eq("rst_async_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_async_s_tready", s_axis_tready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_const(input int x, input int n);
    bit t;
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'(x);
    m_axis_tready = 1'b1;
    while (cnt < n && cyc < n * 4 + 20) begin
      step(t);
      if (t) cnt++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    check_eq("send_count", cnt, n);
  endtask

  task automatic drain(input string tag);
    bit t;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) step(t);
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    bit     t;
    int     xv;
    int     cnt;
    int     cyc;
    longint held;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;

    // Reset state and r_ready release timing
    @(negedge clk);
    check_eq("rst_s_tready", s_axis_tready, 0);
    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_m_tdata", m_axis_tdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rready_before_edge", s_axis_tready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rready_after_edge", s_axis_tready, 1);
    @(posedge clk);
    #1;

    // Constant 100: ramp 10000*k >> 5 then flat 10000
    send_const(100, 40);
    drain("c100_drain");
    check_eq("c100_out0", out_q[0], 312);
    check_eq("c100_out1", out_q[1], 625);
    check_eq("c100_out30", out_q[30], 9687);
    check_eq("c100_out31", out_q[31], 10000);
    check_eq("c100_out39", out_q[39], 10000);

    // Most negative input: square 2^30 exact
    do_reset();
    send_const(-32768, 40);
    drain("neg_drain");
    check_eq("neg_out0", out_q[0], 33554432);
    check_eq("neg_out39", out_q[39], 1073741824);

    // Most positive input
    do_reset();
    send_const(32767, 40);
    drain("pos_drain");
    check_eq("pos_out39", out_q[39], 1073676289);

    // Impulse: 1000 then zeros -> 31250 for exactly 32 outputs, then 0
    do_reset();
    send_const(1000, 1);
    send_const(0, 40);
    drain("imp_drain");
    check_eq("imp_size", out_q.size(), 41);
    cnt = 0;
    foreach (out_q[i]) if (out_q[i] == 31250) cnt++;
    check_eq("imp_count_31250", cnt, 32);
    check_eq("imp_out31", out_q[31], 31250);
    check_eq("imp_out32", out_q[32], 0);
    check_eq("imp_out40", out_q[40], 0);

    // Backpressure: m_axis_tready low for 5 cycles mid-stream
    do_reset();
    s_axis_tvalid = 1'b1;
    xv = 1;
    for (int c = 0; c < 40; c++) begin
      s_axis_tdata  = 16'(xv);
      m_axis_tready = !(c >= 10 && c < 15);
      @(negedge clk);
      if (c == 10) begin
        check_eq("bp_m_tvalid", m_axis_tvalid, 1);
        check_eq("bp_s_tready", s_axis_tready, 0);
        held = longint'(m_axis_tdata);
      end
      if (c > 10 && c < 15) check_eq("bp_tdata_hold", longint'(m_axis_tdata), held);
      t = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (t) xv++;
    end
    s_axis_tvalid = 1'b0;
    drain("bp_drain");
    check_eq("bp_out_count", out_q.size(), xv - 1);

    // Reset mid-stream after 20 samples of 50, then 10s
    do_reset();
    send_const(50, 20);
    do_reset();
    send_const(10, 5);
    drain("mrst_drain");
    check_eq("mrst_out0", out_q[0], 3);
    check_eq("mrst_out4", out_q[4], 15);
    check_eq("mrst_size", out_q.size(), 5);

    // Latency: presented after edge P0, accepted at P1, output valid after P2
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'sd7;
    @(negedge clk);
    check_eq("lat_s_tready", s_axis_tready, 1);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    @(negedge clk);
    check_eq("lat_edge1_m_tvalid", m_axis_tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_edge2_m_tvalid", m_axis_tvalid, 1);
    check_eq("lat_edge2_m_tdata", longint'(m_axis_tdata), 17);
    @(posedge clk);
    #1;
    drain("lat_drain");

    // Random valid/ready with random data against the model
    do_reset();
    cnt = 0;
    cyc = 0;
    s_axis_tvalid = 1'($urandom_range(0, 1));
    s_axis_tdata  = 16'($urandom);
    m_axis_tready = 1'($urandom_range(0, 1));
    while (cnt < 10000 && cyc < 80000) begin
      step(t);
      cyc++;
      if (t) cnt++;
      if (t || !s_axis_tvalid) begin
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = 16'($urandom);
      end
      m_axis_tready = 1'($urandom_range(0, 1));
    end
    check_eq("rand_count", cnt, 10000);
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
